bfp_block_encoder: RTL

Converts a stream of IEEE-754 single-precision words into block-floating-point form: collects BLOCK_SIZE elements, derives one shared exponent from the block maximum, then emits each element as an aligned sign-magnitude word. It is the float-to-BFP front end feeding the BFP datapath. Its output format, SignFrac plus shared Exp, is exactly what the renormalization block consumes on the return path.

---
 rtl/bfp_pkg.sv | 38 +++
 rtl/bfp_align.sv | 50 +++++
 rtl/bfp_block_encoder.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point datapath: IEEE-754 single
// field layout, special exponent codes, encoder state type and small helpers.
// No ports; imported by bfp_align and bfp_block_encoder.
package bfp_pkg;

  localparam int IEEE_EXP_W  = 8;
  localparam int IEEE_MANT_W = 23;
  localparam int EXP_BIAS    = 127;

  // Exponent codes with special meaning in IEEE-754 single.
  localparam logic [IEEE_EXP_W-1:0] EXP_ZERO       = 8'd0;    // zero / denormal
  localparam logic [IEEE_EXP_W-1:0] EXP_SPECIAL    = 8'd255;  // Inf / NaN
  localparam logic [IEEE_EXP_W-1:0] EXP_MAX_FINITE = 8'd254;

  // Width of one aligned sign-magnitude element (sign + 23-bit magnitude).
  localparam int SF_W = 24;

  typedef enum logic {FILL, DRAIN} state_t;

  // Sign-magnitude packing: sign in the MSB, magnitude below it.
  function automatic logic [SF_W-1:0] sm_pack(input logic sign, input logic [SF_W-2:0] mag);
    return {sign, mag};
  endfunction

  // Inf/NaN are ranked as the largest finite exponent.
  function automatic logic [IEEE_EXP_W-1:0] eff_exp(input logic [IEEE_EXP_W-1:0] e);
    return (e == EXP_SPECIAL) ? EXP_MAX_FINITE : e;
  endfunction

  function automatic logic [IEEE_EXP_W-1:0] clamp_exp(input logic [IEEE_EXP_W-1:0] e,
                                                      input logic [IEEE_EXP_W-1:0] lo,
                                                      input logic [IEEE_EXP_W-1:0] hi);
    if (e < lo) return lo;
    if (e > hi) return hi;
    return e;
  endfunction

endpackage

// File: rtl/bfp_align.sv
// Combinational aligner: shifts one IEEE single onto a shared biased exponent,
// producing a truncated sign-magnitude word and a saturation indication.
// Ports: in_data_i (IEEE word), exp_i (biased shared exponent) -> signfrac_o, sat_o.
module bfp_align
  import bfp_pkg::*;
(
  input  logic [31:0]     in_data_i,
  input  logic [7:0]      exp_i,
  output logic [SF_W-1:0] signfrac_o,
  output logic            sat_o
);

  logic                   sign;
  logic [IEEE_EXP_W-1:0]  e;
  logic [IEEE_EXP_W-1:0]  e_eff;
  logic [IEEE_MANT_W-1:0] m;
  logic [SF_W-2:0]        base;
  logic [SF_W-2:0]        mag;
  logic [7:0]             shift;
  logic                   unused_mant_lsb;

  assign sign  = in_data_i[31];
  assign e     = in_data_i[30:23];
  assign m     = in_data_i[22:0];
  assign e_eff = eff_exp(e);

  // Hidden one on top; the mantissa LSB falls off the 23-bit magnitude.
  assign base            = {1'b1, m[IEEE_MANT_W-1 -: SF_W-2]};
  assign unused_mant_lsb = m[0];

  always_comb begin
    mag   = '0;
    sat_o = 1'b0;
    shift = exp_i - e_eff;
    if (e == EXP_ZERO) begin
      mag = '0;
    end else if (e == EXP_SPECIAL || e_eff > exp_i) begin
      // Inf/NaN, or above the clamped shared exponent: full scale.
      mag   = '1;
      sat_o = 1'b1;
    end else if (shift >= 8'(SF_W-1)) begin
      mag = '0;
    end else begin
      mag = base >> shift;
    end
  end

  assign signfrac_o = sm_pack(sign, mag);

endmodule

// File: rtl/bfp_block_encoder.sv
// Float-to-BFP front end: buffers BLOCK_SIZE IEEE singles, picks one shared
// exponent from the block maximum, then drains aligned sign-magnitude words.
// Ports: in_data/in_valid/in_ready (FILL only), out_signfrac/out_exp/out_last/
// out_valid/out_ready (DRAIN, registered, held under stall), sat_flag (sticky per block).
module bfp_block_encoder
  import bfp_pkg::*;
#(
  parameter int BLOCK_SIZE = 8,
  parameter int FRAC_W     = SF_W,          // aligner is built for SF_W; keep equal
  parameter int EXP_W      = 5,
  parameter int EXP_OFFSET = EXP_BIAS - 15  // out_exp 15 corresponds to 2^0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [FRAC_W-1:0] out_signfrac,
  output logic [EXP_W-1:0]  out_exp,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              sat_flag
);

  localparam int               CNT_W    = $clog2(BLOCK_SIZE);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_SIZE - 1);
  localparam logic [7:0]       E_LO     = 8'(EXP_OFFSET);
  localparam logic [7:0]       E_HI     = 8'(EXP_OFFSET + 2**EXP_W - 1);

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        emax_q;
  logic [7:0]        e_q;
  logic [31:0]       blk_buf_q [BLOCK_SIZE];
  logic              in_ready_q;
  logic              out_valid_q;
  logic [FRAC_W-1:0] out_signfrac_q;
  logic [EXP_W-1:0]  out_exp_q;
  logic              out_last_q;
  logic              sat_q;

  logic              in_fire;
  logic              out_fire;
  logic [CNT_W-1:0]  cnt_inc;
  logic [7:0]        in_e_eff;
  logic [7:0]        emax_d;
  logic [7:0]        e_blk;
  logic [31:0]       al_data;
  logic [7:0]        al_exp;
  logic [SF_W-1:0]   al_sf;
  logic              al_sat;

  assign in_fire  = in_valid && in_ready_q;
  assign out_fire = out_valid_q && out_ready;
  assign cnt_inc  = cnt_q + 1'b1;

  // Running max over non-zero exponents, including the beat being accepted,
  // so the shared exponent is ready on the last fill beat.
  assign in_e_eff = eff_exp(in_data[30:23]);
  assign emax_d   = (in_data[30:23] != EXP_ZERO && in_e_eff > emax_q) ? in_e_eff : emax_q;
  assign e_blk    = clamp_exp(emax_d, E_LO, E_HI);

  // On the last fill beat element 0 is aligned with the freshly computed
  // exponent; during drain the next element is pre-aligned with the latched one.
  assign al_data = (state_q == FILL) ? blk_buf_q[0] : blk_buf_q[cnt_inc];
  assign al_exp  = (state_q == FILL) ? e_blk : e_q;

  bfp_align u_align (
    .in_data_i  (al_data),
    .exp_i      (al_exp),
    .signfrac_o (al_sf),
    .sat_o      (al_sat)
  );

  always_ff @(posedge clk) begin
    if (in_fire) blk_buf_q[cnt_q] <= in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= FILL;
      cnt_q          <= '0;
      emax_q         <= '0;
      e_q            <= '0;
      in_ready_q     <= 1'b1;
      out_valid_q    <= 1'b0;
      out_signfrac_q <= '0;
      out_exp_q      <= '0;
      out_last_q     <= 1'b0;
      sat_q          <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_fire) begin
            cnt_q  <= cnt_inc;   // wraps to 0 on the last beat, ready for drain
            emax_q <= emax_d;
            if (cnt_q == CNT_LAST) begin
              state_q        <= DRAIN;
              in_ready_q     <= 1'b0;
              e_q            <= e_blk;
              out_exp_q      <= EXP_W'(e_blk - E_LO);
              out_valid_q    <= 1'b1;
              out_signfrac_q <= al_sf;
              out_last_q     <= 1'b0;
              sat_q          <= sat_q | al_sat;
            end
          end
        end
        DRAIN: begin
          if (out_fire) begin
            if (out_last_q) begin
              state_q     <= FILL;
              in_ready_q  <= 1'b1;
              out_valid_q <= 1'b0;
              out_last_q  <= 1'b0;
              cnt_q       <= '0;
              emax_q      <= '0;
              sat_q       <= 1'b0;
            end else begin
              cnt_q          <= cnt_inc;
              out_signfrac_q <= al_sf;
              out_last_q     <= (cnt_inc == CNT_LAST);
              sat_q          <= sat_q | al_sat;
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign out_valid    = out_valid_q;
  assign out_signfrac = out_signfrac_q;
  assign out_exp      = out_exp_q;
  assign out_last     = out_last_q;
  assign sat_flag     = sat_q;

endmodule
